// File: rtl/jamma_input_scanner_if.sv
// Board-pin and core-side signal bundle for jamma_input_scanner.
// master drives the pins and scan enable; slave is the scanner itself.
interface jamma_input_scanner_if;
  logic       ena;
  logic [7:0] jjoy;
  logic [1:0] jcoin;
  logic [5:0] local_joy;
  logic       jselect;
  logic [7:0] joy1;
  logic [7:0] joy2;
  logic [1:0] coin;
  logic       scan_done;

  modport master (
    output ena, jjoy, jcoin, local_joy,
    input  jselect, joy1, joy2, coin, scan_done
  );

  modport slave (
    input  ena, jjoy, jcoin, local_joy,
    output jselect, joy1, joy2, coin, scan_done
  );
endinterface

// File: rtl/jamma_input_scanner.sv
// JAMMA input mux scanner: alternates P1/P2 select, settles, samples the shared bus.
// Define JAMMA_DEBOUNCE_EN to build the per-slot debounce (DEBOUNCE identical samples).
module jamma_input_scanner #(
  parameter int unsigned SETTLE   = 4,
  parameter int unsigned DEBOUNCE = 3
) (
  input logic                   clk,
  input logic                   reset,
  jamma_input_scanner_if.slave  bus
);

  if (SETTLE < 2 || SETTLE > 255) begin : g_bad_settle
    $error("jamma_input_scanner: SETTLE must be 2..255");
  end
  if (DEBOUNCE < 1 || DEBOUNCE > 15) begin : g_bad_debounce
    $error("jamma_input_scanner: DEBOUNCE must be 1..15");
  end

  localparam logic [7:0] SETTLE_C = 8'(SETTLE);

  typedef enum logic {
    S_P1 = 1'b0,
    S_P2 = 1'b1
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic       take_p1, take_p2;

  logic [7:0] jjoy_m, jjoy_s;
  logic [1:0] jcoin_m, jcoin_s;
  logic [5:0] local_m, local_s;
  logic [7:0] raw1, raw2;
  logic [1:0] rawc;
  logic [7:0] joy1_q, joy2_q;
  logic [1:0] coin_q;
  logic       scan_done_q;

  // Two-flop synchronisers run every clk, regardless of ena.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      jjoy_m  <= '1;
      jjoy_s  <= '1;
      jcoin_m <= '1;
      jcoin_s <= '1;
      local_m <= '1;
      local_s <= '1;
    end else begin
      jjoy_m  <= bus.jjoy;
      jjoy_s  <= jjoy_m;
      jcoin_m <= bus.jcoin;
      jcoin_s <= jcoin_m;
      local_m <= bus.local_joy;
      local_s <= local_m;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_P1;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    take_p1   = 1'b0;
    take_p2   = 1'b0;
    if (bus.ena) begin
      if (cnt == SETTLE_C) begin
        cnt_nxt   = '0;
        take_p1   = (state == S_P1);
        take_p2   = (state == S_P2);
        state_nxt = (state == S_P1) ? S_P2 : S_P1;
      end else begin
        cnt_nxt = cnt + 8'd1;
      end
    end
  end

  assign raw1 = jjoy_s & {2'b11, local_s};
  assign raw2 = jjoy_s;
  assign rawc = jcoin_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) scan_done_q <= 1'b0;
    else       scan_done_q <= take_p2;
  end

`ifdef JAMMA_DEBOUNCE_EN
  localparam logic [4:0] DB_C = 5'(DEBOUNCE);

  logic [7:0] last1, last2;
  logic [1:0] lastc;
  logic [3:0] run1, run2, runc;
  logic [3:0] run1_n, run2_n, runc_n;

  function automatic logic [3:0] run_next(input logic same, input logic [3:0] run);
    if (!same) return '0;
    return (run == 4'hF) ? run : run + 4'd1;
  endfunction

  always_comb begin
    run1_n = run_next(raw1 == last1, run1);
    run2_n = run_next(raw2 == last2, run2);
    runc_n = run_next(rawc == lastc, runc);
  end

  // Output loads once the post-compare run shows DEBOUNCE matching samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last1  <= '1;
      last2  <= '1;
      lastc  <= '1;
      run1   <= '0;
      run2   <= '0;
      runc   <= '0;
      joy1_q <= '1;
      joy2_q <= '1;
      coin_q <= '1;
    end else begin
      if (take_p1) begin
        last1 <= raw1;
        run1  <= run1_n;
        lastc <= rawc;
        runc  <= runc_n;
        if ({1'b0, run1_n} + 5'd1 >= DB_C) joy1_q <= raw1;
        if ({1'b0, runc_n} + 5'd1 >= DB_C) coin_q <= rawc;
      end
      if (take_p2) begin
        last2 <= raw2;
        run2  <= run2_n;
        if ({1'b0, run2_n} + 5'd1 >= DB_C) joy2_q <= raw2;
      end
    end
  end
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      joy1_q <= '1;
      joy2_q <= '1;
      coin_q <= '1;
    end else begin
      if (take_p1) begin
        joy1_q <= raw1;
        coin_q <= rawc;
      end
      if (take_p2) joy2_q <= raw2;
    end
  end
`endif

  assign bus.jselect   = (state == S_P2);
  assign bus.joy1      = joy1_q;
  assign bus.joy2      = joy2_q;
  assign bus.coin      = coin_q;
  assign bus.scan_done = scan_done_q;

endmodule

// File: tb/tb_jamma_input_scanner.sv
// Scoreboard bench for jamma_input_scanner: per-scan expectations from a sample-history model.
module tb_jamma_input_scanner;

  localparam int unsigned SETTLE   = 4;
  localparam int unsigned DEBOUNCE = 3;
`ifdef JAMMA_DEBOUNCE_EN
  localparam int unsigned DB_MODEL = DEBOUNCE;
`else
  localparam int unsigned DB_MODEL = 1;
`endif
  localparam int unsigned SCAN_ENA = 2 * (SETTLE + 1);

  logic clk = 1'b0;
  logic reset = 1'b0;

  jamma_input_scanner_if bus ();

  jamma_input_scanner #(.SETTLE(SETTLE), .DEBOUNCE(DEBOUNCE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // External mux: the board routes the selected player's switches onto jjoy.
  logic [7:0] p1_pin = 8'hFF;
  logic [7:0] p2_pin = 8'hFF;
  assign bus.jjoy = bus.jselect ? p2_pin : p1_pin;

  typedef struct packed {
    logic [7:0] j1;
    logic [7:0] j2;
    logic [1:0] c;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned scans_seen = 0;
  int unsigned ena_cnt = 0;
  bit          ena_auto = 1'b0;
  bit          ena_rand = 1'b0;

  // Model: per slot, a history of samples (newest at 0); seeded with the all-released state.
  logic [7:0]  hist[3][16];
  int unsigned hist_len[3];
  logic [7:0]  m_out[3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int s = 0; s < 3; s++) begin
      hist[s][0]  = (s == 2) ? 8'h03 : 8'hFF;
      hist_len[s] = 1;
      m_out[s]    = hist[s][0];
    end
  endfunction

  function automatic void slot_sample(input int s, input logic [7:0] v);
    int unsigned same;
    bit          run;
    for (int i = 15; i > 0; i--) hist[s][i] = hist[s][i-1];
    hist[s][0] = v;
    if (hist_len[s] < 16) hist_len[s]++;
    same = 0;
    run  = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (run && i < int'(hist_len[s]) && hist[s][i] == v) same++;
      else run = 1'b0;
    end
    if (same >= DB_MODEL) m_out[s] = v;
  endfunction

  // Issue one scan's pin values and push the outputs expected when it completes.
  task automatic issue_scan(input logic [7:0] p1, input logic [7:0] p2,
                            input logic [1:0] c, input logic [5:0] loc);
    exp_t e;
    p1_pin        = p1;
    p2_pin        = p2;
    bus.jcoin     = c;
    bus.local_joy = loc;
    slot_sample(0, p1 & {2'b11, loc});
    slot_sample(1, p2);
    slot_sample(2, {6'b0, c});
    e.j1 = m_out[0];
    e.j2 = m_out[1];
    e.c  = m_out[2][1:0];
    exp_q.push_back(e);
  endtask

  task automatic wait_scans(input int unsigned target);
    int unsigned t = 0;
    while (scans_seen < target && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (scans_seen < target) begin
      n_tests++;
      n_fail++;
      $display("FAIL scan_timeout: got %0d scans expected %0d", scans_seen, target);
    end
  endtask

  task automatic do_scan(input logic [7:0] p1, input logic [7:0] p2,
                         input logic [1:0] c, input logic [5:0] loc);
    int unsigned s0 = scans_seen;
    issue_scan(p1, p2, c, loc);
    wait_scans(s0 + 1);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (ena_auto) bus.ena = ena_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // Monitor: scan length in ena cycles and scoreboard compare on every scan_done.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        ena_cnt = 0;
      end else begin
        if (bus.ena) ena_cnt++;
        if (bus.scan_done) begin
          scans_seen++;
          chk("scan_len", ena_cnt, SCAN_ENA);
          chk("jselect_after_scan", bus.jselect, 0);
          ena_cnt = 0;
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_scan: got scan_done expected none");
          end else begin
            e = exp_q.pop_front();
            chk("joy1", bus.joy1, e.j1);
            chk("joy2", bus.joy2, e.j2);
            chk("coin", bus.coin, e.c);
          end
        end
      end
    end
  end

  initial begin
    logic [7:0]  r1, r2, snap_j1, snap_j2;
    logic [1:0]  rc, snap_c;
    logic [5:0]  rl;
    logic        snap_sel;
    int unsigned s0;

    bus.ena       = 1'b1;
    bus.jcoin     = 2'b11;
    bus.local_joy = 6'h3F;
    model_reset();
    #1 reset = 1'b1;
    #2;
    chk("rst_joy1", bus.joy1, 8'hFF);
    chk("rst_joy2", bus.joy2, 8'hFF);
    chk("rst_coin", bus.coin, 2'b11);
    chk("rst_jselect", bus.jselect, 0);
    chk("rst_scan_done", bus.scan_done, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    ena_auto = 1'b1;

    // Idle pins: select toggles every SETTLE+1 clk from 0.
    s0 = scans_seen;
    issue_scan(8'hFF, 8'hFF, 2'b11, 6'h3F);
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk);
      #1;
      chk("jselect_seq", bus.jselect, ((n / 5) % 2));
    end
    wait_scans(s0 + 1);
    do_scan(8'hFF, 8'hFF, 2'b11, 6'h3F);

    // Persistent presses on both players.
    repeat (4) do_scan(8'hFE, 8'h7F, 2'b11, 6'h3F);
    // Single-scan glitch on P1 bit 2.
    repeat (2) do_scan(8'hFF, 8'hFF, 2'b11, 6'h3F);
    do_scan(8'hFB, 8'hFF, 2'b11, 6'h3F);
    repeat (3) do_scan(8'hFF, 8'hFF, 2'b11, 6'h3F);
    // On-board joystick merges into P1 only; coin press.
    repeat (3) do_scan(8'hFF, 8'hFF, 2'b10, 6'h3E);
    repeat (3) do_scan(8'hFF, 8'hFF, 2'b11, 6'h3F);

    // ena held low mid-phase: everything frozen, no extra sample afterwards.
    s0 = scans_seen;
    issue_scan(8'hFE, 8'h7F, 2'b01, 6'h3F);
    repeat (7) @(negedge clk);
    ena_auto = 1'b0;
    bus.ena  = 1'b0;
    @(posedge clk);
    #1;
    snap_sel = bus.jselect;
    snap_j1  = bus.joy1;
    snap_j2  = bus.joy2;
    snap_c   = bus.coin;
    for (int n = 0; n < 50; n++) begin
      @(posedge clk);
      #1;
      chk("freeze", {bus.scan_done, bus.jselect, bus.joy1, bus.joy2, bus.coin},
          {1'b0, snap_sel, snap_j1, snap_j2, snap_c});
    end
    @(negedge clk);
    bus.ena  = 1'b1;
    ena_auto = 1'b1;
    wait_scans(s0 + 1);
    repeat (3) do_scan(8'hFE, 8'h7F, 2'b01, 6'h3F);

    // Reset at cnt=3 in S_P2 with non-idle outputs.
    s0 = scans_seen;
    issue_scan(8'hFE, 8'h7F, 2'b01, 6'h3F);
    wait_scans(s0 + 1);
    repeat (8) @(posedge clk);
    #1;
    chk("pre_reset_jselect", bus.jselect, 1);
    chk("pre_reset_joy1", bus.joy1, 8'hFE);
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    model_reset();
    #1;
    chk("mid_rst_joy1", bus.joy1, 8'hFF);
    chk("mid_rst_joy2", bus.joy2, 8'hFF);
    chk("mid_rst_coin", bus.coin, 2'b11);
    chk("mid_rst_jselect", bus.jselect, 0);
    @(negedge clk);
    reset = 1'b0;
    s0 = scans_seen;
    issue_scan(8'hFE, 8'h7F, 2'b01, 6'h3F);
    for (int n = 1; n <= 5; n++) begin
      @(posedge clk);
      #1;
      chk("post_rst_jselect", bus.jselect, (n >= 5) ? 1 : 0);
      chk("post_rst_joy1", bus.joy1, (n >= 5 && DB_MODEL == 1) ? 8'hFE : 8'hFF);
    end
    wait_scans(s0 + 1);
    repeat (3) do_scan(8'hFE, 8'h7F, 2'b01, 6'h3F);

    // Randomised pins (biased to repeat) with random ena.
    ena_rand = 1'b1;
    r1 = 8'hFF; r2 = 8'hFF; rc = 2'b11; rl = 6'h3F;
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0) r1 = 8'($urandom);
      if ($urandom_range(0, 3) == 0) r2 = 8'($urandom);
      if ($urandom_range(0, 3) == 0) rc = 2'($urandom);
      if ($urandom_range(0, 5) == 0) rl = 6'($urandom);
      do_scan(r1, r2, rc, rl);
    end
    ena_rand = 1'b0;

    repeat (5) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
